// File: rtl/ddr3_cmd_responder.sv
// DDR3 command responder: tracks the device init sequence (MR2, MR3, MR1, MR0, ZQCL) and decodes commands.
// Define DDR3_RESP_TIMING_CHECK_EN to add the tMRD, tMOD and ZQ-window timing checks.
module ddr3_cmd_responder #(
    parameter int unsigned TMRD    = 4,
    parameter int unsigned TMOD    = 12,
    parameter int unsigned TZQINIT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ddr3_reset_in,
    input  logic        ddr3_cke_in,
    input  logic        ddr3_cs_in,
    input  logic        ddr3_ras_in,
    input  logic        ddr3_cas_in,
    input  logic        ddr3_we_in,
    input  logic [2:0]  ddr3_ba_in,
    input  logic [13:0] ddr3_addr_in,
    output logic [13:0] mr0,
    output logic [13:0] mr1,
    output logic [13:0] mr2,
    output logic [13:0] mr3,
    output logic        cmd_valid,
    output logic [3:0]  cmd_code,
    output logic        init_done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        zq_busy
);

    localparam int unsigned    ZqW     = $clog2(TZQINIT + 1);
    localparam logic [ZqW-1:0] ZqLoad  = ZqW'(TZQINIT);
    localparam logic [ZqW-1:0] ZqOne   = ZqW'(1);
    localparam logic [3:0]     CmdNop  = 4'b0111;
    localparam logic [3:0]     CmdMrs  = 4'b0000;
    localparam logic [3:0]     CmdZqcl = 4'b0110;

    typedef enum logic [3:0] {
        RstHeld, WaitCke, WaitMr2, WaitMr3, WaitMr1, WaitMr0, WaitZq, ZqRun, Ready, Fail
    } state_e;

    state_e         state_q, mr_next;
    logic [ZqW-1:0] zq_cnt_q;
    logic [1:0]     rst_sync_q;
    logic [3:0]     cmd;
    logic [2:0]     mr_ba, zq_code;
    logic           run, cmd_is_nop, cmd_is_mrs, cmd_is_zqcl;
    logic           tmrd_bad, tmod_bad, in_mr_wait, init_mrs_ok, mr_load;

    // Reset release is synchronised; the FSM is frozen until the sync chain fills.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign run         = rst_sync_q[1];
    assign cmd         = {ddr3_cs_in, ddr3_ras_in, ddr3_cas_in, ddr3_we_in};
    assign cmd_is_nop  = ddr3_cs_in || (cmd == CmdNop);
    assign cmd_is_mrs  = (cmd == CmdMrs);
    assign cmd_is_zqcl = (cmd == CmdZqcl);

`ifdef DDR3_RESP_TIMING_CHECK_EN
    localparam logic [9:0] GapMax  = 10'd1023;
    localparam logic [9:0] TmrdGap = 10'(TMRD);
    localparam logic [9:0] TmodGap = 10'(TMOD);
    logic [9:0] gap_q;

    // Cycles since the last accepted-for-sampling MRS; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        gap_q <= '0;
        else if (run && ddr3_reset_in && cmd_is_mrs)     gap_q <= 10'd1;
        else if (gap_q != GapMax)                        gap_q <= gap_q + 10'd1;
    end

    assign tmrd_bad = (gap_q < TmrdGap);
    assign tmod_bad = (gap_q < TmodGap);
    assign zq_code  = 3'd4;
`else
    assign tmrd_bad = 1'b0;
    assign tmod_bad = 1'b0;
    assign zq_code  = 3'd1;
`endif

    always_comb begin
        mr_ba   = 3'd2;
        mr_next = WaitMr3;
        case (state_q)
            WaitMr3: begin mr_ba = 3'd3; mr_next = WaitMr1; end
            WaitMr1: begin mr_ba = 3'd1; mr_next = WaitMr0; end
            WaitMr0: begin mr_ba = 3'd0; mr_next = WaitZq;  end
            default: ;
        endcase
    end

    assign in_mr_wait  = (state_q == WaitMr2) || (state_q == WaitMr3) ||
                         (state_q == WaitMr1) || (state_q == WaitMr0);
    // MR2 opens the sequence, so there is no earlier MRS to measure tMRD against.
    assign init_mrs_ok = cmd_is_mrs && (ddr3_ba_in == mr_ba) &&
                         !((state_q != WaitMr2) && tmrd_bad);
    assign mr_load     = run && ddr3_reset_in && cmd_is_mrs &&
                         ((state_q == Ready) || (in_mr_wait && init_mrs_ok));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mr0 <= '0;
            mr1 <= '0;
            mr2 <= '0;
            mr3 <= '0;
        end else if (mr_load) begin
            case (ddr3_ba_in)
                3'd0:    mr0 <= ddr3_addr_in;
                3'd1:    mr1 <= ddr3_addr_in;
                3'd2:    mr2 <= ddr3_addr_in;
                3'd3:    mr3 <= ddr3_addr_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RstHeld;
            zq_cnt_q  <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= CmdNop;
            init_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= 3'd0;
            zq_busy   <= 1'b0;
        end else if (run) begin
            cmd_valid <= 1'b0;
            if (state_q != Fail && !ddr3_reset_in) begin
                state_q   <= RstHeld;
                init_done <= 1'b0;
                zq_busy   <= 1'b0;
            end else begin
                if (!cmd_is_nop && state_q != RstHeld && state_q != Fail) begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= cmd;
                end
                case (state_q)
                    RstHeld: state_q <= WaitCke;
                    WaitCke: begin
                        if (!cmd_is_nop) begin
                            state_q <= Fail; err <= 1'b1; err_code <= 3'd1;
                        end else if (ddr3_cke_in) begin
                            state_q <= WaitMr2;
                        end
                    end
                    WaitMr2, WaitMr3, WaitMr1, WaitMr0: begin
                        if (!cmd_is_nop) begin
                            if (init_mrs_ok) begin
                                state_q <= mr_next;
                            end else begin
                                state_q  <= Fail;
                                err      <= 1'b1;
                                err_code <= (cmd_is_mrs && ddr3_ba_in == mr_ba) ? 3'd2 : 3'd1;
                            end
                        end
                    end
                    WaitZq: begin
                        if (!cmd_is_nop) begin
                            if (!cmd_is_zqcl) begin
                                state_q <= Fail; err <= 1'b1; err_code <= 3'd1;
                            end else if (tmod_bad) begin
                                state_q <= Fail; err <= 1'b1; err_code <= 3'd3;
                            end else begin
                                state_q  <= ZqRun;
                                zq_cnt_q <= ZqLoad;
                                zq_busy  <= 1'b1;
                            end
                        end
                    end
                    ZqRun: begin
                        if (!cmd_is_nop) begin
                            state_q  <= Fail;
                            err      <= 1'b1;
                            err_code <= zq_code;
                            zq_busy  <= 1'b0;
                        end else if (zq_cnt_q == '0) begin
                            state_q   <= Ready;
                            init_done <= 1'b1;
                            zq_busy   <= 1'b0;
                        end else begin
                            zq_cnt_q <= zq_cnt_q - ZqOne;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Randomised bench for ddr3_cmd_responder; expectations come from sequence-level rules kept here.
module tb_ddr3_cmd_responder;

    localparam int unsigned TMRD    = 4;
    localparam int unsigned TMOD    = 12;
    localparam int unsigned TZQINIT = 512;
    localparam logic [3:0]  NOP  = 4'b0111;
    localparam logic [3:0]  MRS  = 4'b0000;
    localparam logic [3:0]  ZQCL = 4'b0110;
`ifdef DDR3_RESP_TIMING_CHECK_EN
    localparam bit TimingEn = 1'b1;
`else
    localparam bit TimingEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ddr3_reset_in = 1'b0, cke = 1'b0;
    logic        cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
    logic [2:0]  ba = 3'd0;
    logic [13:0] addr = 14'd0;
    logic [13:0] mr0, mr1, mr2, mr3;
    logic        cmd_valid, init_done, err, zq_busy;
    logic [3:0]  cmd_code;
    logic [2:0]  err_code;
    logic [13:0] mr_obs [4];
    logic [13:0] exp_mr [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    ddr3_cmd_responder #(.TMRD(TMRD), .TMOD(TMOD), .TZQINIT(TZQINIT)) dut (
        .clk(clk), .rst(rst), .ddr3_reset_in(ddr3_reset_in), .ddr3_cke_in(cke),
        .ddr3_cs_in(cs), .ddr3_ras_in(ras), .ddr3_cas_in(cas), .ddr3_we_in(we),
        .ddr3_ba_in(ba), .ddr3_addr_in(addr),
        .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .init_done(init_done),
        .err(err), .err_code(err_code), .zq_busy(zq_busy)
    );

    assign mr_obs[0] = mr0;
    assign mr_obs[1] = mr1;
    assign mr_obs[2] = mr2;
    assign mr_obs[3] = mr3;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One command per cycle; outputs are read 1 time unit after the sampling edge.
    task automatic step(input logic [3:0] c, input logic [2:0] b, input logic [13:0] a);
        {cs, ras, cas, we} = c;
        ba   = b;
        addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(NOP, 3'd0, 14'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ddr3_reset_in = 1'b0;
        cke = 1'b0;
        nops(2);
        rst = 1'b1;
        nops(3);
        for (int i = 0; i < 4; i++) exp_mr[i] = 14'd0;
    endtask

    task automatic bring_up();
        ddr3_reset_in = 1'b1;
        nops(1);
        cke = 1'b1;
        nops(1);
    endtask

    // idx 0..3 sends MR2, MR3, MR1, MR0 with a random legal spacing.
    task automatic send_mrs(input int idx);
        logic [2:0]  b;
        logic [13:0] a;
        int          gap;
        b   = (idx == 0) ? 3'd2 : (idx == 1) ? 3'd3 : (idx == 2) ? 3'd1 : 3'd0;
        gap = (idx == 0) ? 1 + int'($urandom_range(0, 2)) : int'(TMRD) + int'($urandom_range(0, 3));
        a   = 14'($urandom);
        nops(gap - 1);
        step(MRS, b, a);
        exp_mr[b[1:0]] = a;
    endtask

    task automatic init_to_zq();
        do_reset();
        bring_up();
        for (int i = 0; i < 4; i++) send_mrs(i);
        nops(int'(TMOD) - 1 + int'($urandom_range(0, 3)));
        step(ZQCL, 3'd0, 14'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_tests++; if ({mr0, mr1, mr2, mr3} !== 56'd0) begin n_fail++; $display("FAIL reset_mr: got %h want 0", {mr0, mr1, mr2, mr3}); end
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        n_tests++; if (cmd_code !== 4'b0111) begin n_fail++; $display("FAIL reset_cmd_code: got %b want 0111", cmd_code); end
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_tests++; if (err !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_code); end
        n_tests++; if (zq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_zq_busy: got %b want 0", zq_busy); end
        ddr3_reset_in = 1'b1;
        cke = 1'b1;
        step(MRS, 3'd2, 14'h1234);
        n_tests++; if (cmd_valid !== 1'b0 || mr2 !== 14'd0) begin n_fail++; $display("FAIL reset_held_cmd: got valid=%b mr2=%h want 0/0", cmd_valid, mr2); end
    endtask

    task automatic test_legal_init();
        init_to_zq();
        n_tests++; if (zq_busy !== 1'b1) begin n_fail++; $display("FAIL zq_busy_start: got %b want 1", zq_busy); end
        nops(int'(TZQINIT));
        n_tests++; if (init_done !== 1'b0 || zq_busy !== 1'b1) begin n_fail++; $display("FAIL zq_early: got done=%b busy=%b want 0/1", init_done, zq_busy); end
        nops(1);
        n_tests++; if (init_done !== 1'b1 || zq_busy !== 1'b0) begin n_fail++; $display("FAIL zq_end: got done=%b busy=%b want 1/0", init_done, zq_busy); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL legal_err: got %b want 0", err); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (mr_obs[i] !== exp_mr[i]) begin n_fail++; $display("FAIL legal_mr%0d: got %h want %h", i, mr_obs[i], exp_mr[i]); end
        end
    endtask

    task automatic test_ready_decode();
        for (int k = 0; k < 28; k++) begin
            logic [3:0]  c;
            logic [2:0]  b;
            logic [13:0] a;
            logic        ev;
            c = 4'($urandom);
            if (k < 4) c = MRS;
            else if ($urandom_range(0, 2) != 0) c[3] = 1'b0;
            b   = (k < 4) ? 3'(k) : 3'($urandom);
            a   = 14'($urandom);
            cke = 1'($urandom);
            step(c, b, a);
            ev = !c[3] && (c != NOP);
            if (c == MRS && b < 3'd4) exp_mr[b[1:0]] = a;
            n_tests++; if (cmd_valid !== ev) begin n_fail++; $display("FAIL ready_valid: cmd=%b got %b want %b", c, cmd_valid, ev); end
            if (ev) begin
                n_tests++; if (cmd_code !== c) begin n_fail++; $display("FAIL ready_code: got %b want %b", cmd_code, c); end
            end
        end
        cke = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (mr_obs[i] !== exp_mr[i]) begin n_fail++; $display("FAIL ready_mr%0d: got %h want %h", i, mr_obs[i], exp_mr[i]); end
        end
        n_tests++; if (err !== 1'b0 || init_done !== 1'b1) begin n_fail++; $display("FAIL ready_state: got err=%b done=%b want 0/1", err, init_done); end
    endtask

    task automatic test_order_error();
        do_reset();
        bring_up();
        nops(int'($urandom_range(0, 3)));
        step(MRS, 3'd3, 14'($urandom));
        n_tests++; if (err !== 1'b1 || err_code !== 3'd1) begin n_fail++; $display("FAIL order_err: got %b/%0d want 1/1", err, err_code); end
        step(MRS, 3'd2, 14'($urandom));
        nops(int'(TMRD) - 1);
        step(MRS, 3'd3, 14'($urandom));
        ddr3_reset_in = 1'b0;
        nops(2);
        ddr3_reset_in = 1'b1;
        nops(2);
        n_tests++; if (err !== 1'b1 || err_code !== 3'd1) begin n_fail++; $display("FAIL order_sticky: got %b/%0d want 1/1", err, err_code); end
        n_tests++; if (mr2 !== 14'd0 || mr3 !== 14'd0 || init_done !== 1'b0) begin n_fail++; $display("FAIL order_frozen: got mr2=%h mr3=%h done=%b want 0/0/0", mr2, mr3, init_done); end
    endtask

    task automatic test_tmrd();
        int gaps [3];
        gaps[0] = int'(TMRD) - 1;
        gaps[1] = int'(TMRD);
        gaps[2] = int'(TMRD) + int'($urandom_range(1, 5));
        for (int g = 0; g < 3; g++) begin
            logic [13:0] a1, a2;
            logic        exp_err;
            a1 = 14'($urandom);
            a2 = 14'($urandom);
            exp_err = TimingEn && (gaps[g] < int'(TMRD));
            do_reset();
            bring_up();
            step(MRS, 3'd2, a1);
            nops(gaps[g] - 1);
            step(MRS, 3'd3, a2);
            n_tests++; if (err !== exp_err || err_code !== (exp_err ? 3'd2 : 3'd0)) begin n_fail++; $display("FAIL tmrd_gap%0d: got %b/%0d want %b/%0d", gaps[g], err, err_code, exp_err, exp_err ? 2 : 0); end
            n_tests++; if (mr3 !== (exp_err ? 14'd0 : a2) || mr2 !== a1) begin n_fail++; $display("FAIL tmrd_mr_gap%0d: got mr2=%h mr3=%h", gaps[g], mr2, mr3); end
        end
    endtask

    task automatic test_tmod();
        for (int g = int'(TMOD) - 1; g <= int'(TMOD); g++) begin
            logic exp_err;
            exp_err = TimingEn && (g < int'(TMOD));
            do_reset();
            bring_up();
            for (int i = 0; i < 4; i++) send_mrs(i);
            nops(g - 1);
            step(ZQCL, 3'd0, 14'd0);
            n_tests++; if (err !== exp_err || err_code !== (exp_err ? 3'd3 : 3'd0)) begin n_fail++; $display("FAIL tmod_gap%0d: got %b/%0d want %b/%0d", g, err, err_code, exp_err, exp_err ? 3 : 0); end
            n_tests++; if (zq_busy !== !exp_err) begin n_fail++; $display("FAIL tmod_busy_gap%0d: got %b want %b", g, zq_busy, !exp_err); end
        end
    endtask

    task automatic test_zq_cmd();
        init_to_zq();
        nops(99);
        step(MRS, 3'($urandom_range(0, 3)), 14'($urandom));
        n_tests++; if (err !== 1'b1 || err_code !== (TimingEn ? 3'd4 : 3'd1)) begin n_fail++; $display("FAIL zq_cmd: got %b/%0d want 1/%0d", err, err_code, TimingEn ? 4 : 1); end
        nops(int'(TZQINIT));
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL zq_cmd_done: got %b want 0", init_done); end
    endtask

    task automatic test_ddr_reset();
        do_reset();
        bring_up();
        send_mrs(0);
        send_mrs(1);
        ddr3_reset_in = 1'b0;
        nops(1);
        n_tests++; if (init_done !== 1'b0 || zq_busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL ddr_reset_flags: got done=%b busy=%b err=%b want 0/0/0", init_done, zq_busy, err); end
        n_tests++; if (mr2 !== exp_mr[2] || mr3 !== exp_mr[3]) begin n_fail++; $display("FAIL ddr_reset_keep: got %h/%h want %h/%h", mr2, mr3, exp_mr[2], exp_mr[3]); end
        step(MRS, 3'd1, 14'($urandom) | 14'd1);
        n_tests++; if (mr1 !== 14'd0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL ddr_reset_ignore: got mr1=%h valid=%b want 0/0", mr1, cmd_valid); end
        bring_up();
        for (int i = 0; i < 4; i++) send_mrs(i);
        nops(int'(TMOD) - 1);
        step(ZQCL, 3'd0, 14'd0);
        nops(int'(TZQINIT) + 1);
        n_tests++; if (init_done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL ddr_reset_restart: got done=%b err=%b want 1/0", init_done, err); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (mr_obs[i] !== exp_mr[i]) begin n_fail++; $display("FAIL restart_mr%0d: got %h want %h", i, mr_obs[i], exp_mr[i]); end
        end
    endtask

    task automatic test_rst_mid_zq();
        init_to_zq();
        nops(int'($urandom_range(10, 200)));
        n_tests++; if (zq_busy !== 1'b1 || cmd_code !== ZQCL) begin n_fail++; $display("FAIL mid_zq_pre: got busy=%b code=%b want 1/0110", zq_busy, cmd_code); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if ({mr0, mr1, mr2, mr3} !== 56'd0 || cmd_code !== NOP || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_zq_rst_cmd: got mr=%h code=%b valid=%b", {mr0, mr1, mr2, mr3}, cmd_code, cmd_valid); end
        n_tests++; if (zq_busy !== 1'b0 || init_done !== 1'b0 || err !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL mid_zq_rst_flags: got busy=%b done=%b err=%b code=%0d want 0", zq_busy, init_done, err, err_code); end
    endtask

    initial begin
        test_reset();
        test_legal_init();
        test_ready_decode();
        test_order_error();
        test_tmrd();
        test_tmod();
        test_zq_cmd();
        test_ddr_reset();
        test_rst_mid_zq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_responder.md
DDR3_CMD_RESPONDER -- requirements
Module: ddr3_cmd_responder

Interface
REQ-001 Parameter TMRD, default 4: minimum clk cycles from one MRS to the next MRS.
REQ-002 Parameter TMOD, default 12: minimum clk cycles from MR0 MRS to ZQCL.
REQ-003 Parameter TZQINIT, default 512: clk cycles after ZQCL during which only NOP/deselect is legal.
REQ-004 clk  in  1  sole clock; all sampling on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ddr3_reset_in  in  1  device RESET# (low = device held in reset).
REQ-007 ddr3_cke_in  in  1  clock enable.
REQ-008 ddr3_cs_in, ddr3_ras_in, ddr3_cas_in, ddr3_we_in  in  1 each  command pins; command = {cs,ras,cas,we}.
REQ-009 ddr3_ba_in  in  3  bank address; ddr3_addr_in  in  14  address.
REQ-010 mr0, mr1, mr2, mr3  out  14 each  captured mode-register contents.
REQ-011 cmd_valid  out  1  one-cycle pulse per decoded non-NOP, non-deselect command; cmd_code  out  4  that command.
REQ-012 init_done  out  1  init sequence completed legally.
REQ-013 err  out  1  sticky error flag; err_code  out  3  first error cause.
REQ-014 zq_busy  out  1  ZQ calibration window active.

Function
REQ-015 Encodings: NOP 0111, MRS 0000, ZQCL 0110; cs=1 = deselect, treated as NOP.
REQ-016 All outputs registered; each is updated 1 cycle after the command is sampled.
REQ-017 States: RST_HELD, WAIT_CKE, WAIT_MR2, WAIT_MR3, WAIT_MR1, WAIT_MR0, WAIT_ZQ, ZQ_RUN, READY, FAIL.
REQ-018 RST_HELD -> WAIT_CKE when ddr3_reset_in=1; WAIT_CKE -> WAIT_MR2 when ddr3_cke_in=1.
REQ-019 Legal order MR2, MR3, MR1, MR0, selected by ba; a matching MRS advances one state and loads addr into mrN.
REQ-020 WAIT_ZQ -> ZQ_RUN on ZQCL: load zq counter with TZQINIT and assert zq_busy; counter decrements every cycle; at 0 -> READY, init_done=1, zq_busy=0.
REQ-021 Any other non-NOP command in WAIT_CKE..ZQ_RUN -> FAIL, err=1, err_code=1 (order).
REQ-022 In READY every command is decoded to cmd_valid/cmd_code; MRS also updates mrN per ba; CKE low in READY is legal.
REQ-023 ddr3_reset_in=0 in any state other than FAIL -> RST_HELD next cycle; clears init_done and zq_busy, keeps mrN; commands are ignored while it is low.
REQ-024 FAIL is terminal until rst; err and err_code hold the first error; later errors do not overwrite them.
REQ-025 Gap counter counts cycles since the last MRS and saturates at 1023, so wrap-around is not permitted.
REQ-026 An MRS at cycle t followed by an MRS at t+TMRD is legal; the same at t+TMRD-1 is illegal.

Reset
REQ-027 On rst low: state RST_HELD; mr0..mr3=0; cmd_valid=0; cmd_code=0111; init_done=0; err=0; err_code=0; zq_busy=0; counters=0.
REQ-028 rst deassertion is synchronised internally; the first state change happens no earlier than the 2nd rising edge after release.

Configuration
REQ-029 Macro DDR3_RESP_TIMING_CHECK_EN defined: the tMRD gap violation sets err_code=2, the MR0->ZQCL gap < TMOD sets err_code=3, and a non-NOP during ZQ_RUN sets err_code=4; each violation enters FAIL.
REQ-030 Macro undefined: no timing checks and no gap counter is synthesised; a non-NOP during ZQ_RUN is still an order error (code 1).

Verification
REQ-031 Legal sequence (reset high, CKE high, MRS ba=2/3/1/0 spaced 4 cycles, ZQCL 12 cycles after MR0, 512 NOPs) -> init_done=1 at ZQCL+513 cycles, mr values match addr, err=0.
REQ-032 MR3 issued before MR2 -> err=1, err_code=1 one cycle later; state stays FAIL through the remaining legal commands.
REQ-033 With DDR3_RESP_TIMING_CHECK_EN: MR3 sent 3 cycles after MR2 -> err_code=2; sent 4 cycles after -> no error.
REQ-034 ZQCL, then MRS at ZQCL+100 -> err_code=4 with the macro defined, err_code=1 with it undefined.
REQ-035 ddr3_reset_in dropped during WAIT_MR1 -> RST_HELD, init_done=0, mr2/mr3 retained; a full restart then completes legally.
REQ-036 rst asserted mid-ZQ_RUN -> all outputs immediately take their REQ-027 reset values.
